// File: rtl/gpio_irq_sequencer.sv
// APB master that configures one GPIO block after reset, then services its
// interrupt line and forwards each captured pending-bit vector over valid/ready.
module gpio_irq_sequencer #(
    parameter logic [31:0] GPIO_BASE   = 32'h0000_0000,
    parameter logic [31:0] CFG_CONTROL = 32'h0000_0000,
    parameter logic [31:0] CFG_EDGE    = 32'hFFFF_FFFF,
    parameter logic [31:0] CFG_POL     = 32'hFFFF_FFFF,
    parameter logic [31:0] CFG_MASK    = 32'h0000_0000
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    output logic        PSEL,
    output logic        PENABLE,
    output logic [31:0] PADDR,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        gpio_irq,
    output logic        init_done,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [31:0] evt_data,
    output logic [15:0] evt_count
);

    localparam logic [31:0] OFF_CONTROL = 32'h0000_0000;
    localparam logic [31:0] OFF_MASK    = 32'h0000_0008;
    localparam logic [31:0] OFF_IRQ     = 32'h0000_000C;
    localparam logic [31:0] OFF_EDGE    = 32'h0000_0010;
    localparam logic [31:0] OFF_POL     = 32'h0000_0014;

    typedef enum logic [2:0] {
        W_CTRL,
        W_EDGE,
        W_POL,
        W_MASK,
        IDLE,
        RD_IRQ,
        CLR_IRQ,
        PUSH
    } state_t;

    state_t      state, state_next;
    logic        access, access_next;
    logic        psel_next, penable_next, pwrite_next;
    logic [31:0] paddr_next, pwdata_next;
    logic        init_done_next, evt_valid_next;
    logic [31:0] evt_data_next;
    logic [15:0] evt_count_next;
    logic [31:0] cfg_off, cfg_data;
    state_t      cfg_follow;

    // Outputs are the registered image of the current state/phase, so the bus
    // runs one cycle behind the state register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= W_CTRL;
            access    <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= 32'h0;
            PWRITE    <= 1'b0;
            PWDATA    <= 32'h0;
            init_done <= 1'b0;
            evt_valid <= 1'b0;
            evt_data  <= 32'h0;
            evt_count <= 16'h0;
        end else begin
            state     <= state_next;
            access    <= access_next;
            PSEL      <= psel_next;
            PENABLE   <= penable_next;
            PADDR     <= paddr_next;
            PWRITE    <= pwrite_next;
            PWDATA    <= pwdata_next;
            init_done <= init_done_next;
            evt_valid <= evt_valid_next;
            evt_data  <= evt_data_next;
            evt_count <= evt_count_next;
        end
    end

    always_comb begin
        cfg_off    = OFF_CONTROL;
        cfg_data   = CFG_CONTROL;
        cfg_follow = W_EDGE;
        case (state)
            W_EDGE:  begin cfg_off = OFF_EDGE; cfg_data = CFG_EDGE; cfg_follow = W_POL;  end
            W_POL:   begin cfg_off = OFF_POL;  cfg_data = CFG_POL;  cfg_follow = W_MASK; end
            W_MASK:  begin cfg_off = OFF_MASK; cfg_data = CFG_MASK; cfg_follow = IDLE;   end
            default: ;
        endcase
    end

    always_comb begin
        state_next     = state;
        access_next    = access;
        psel_next      = 1'b0;
        penable_next   = 1'b0;
        paddr_next     = PADDR;
        pwrite_next    = PWRITE;
        pwdata_next    = PWDATA;
        init_done_next = init_done;
        evt_valid_next = evt_valid & ~evt_ready;
        evt_data_next  = evt_data;
        evt_count_next = evt_count;

        case (state)
            W_CTRL, W_EDGE, W_POL, W_MASK: begin
                psel_next    = 1'b1;
                penable_next = access;
                paddr_next   = GPIO_BASE + cfg_off;
                pwrite_next  = 1'b1;
                pwdata_next  = cfg_data;
                access_next  = ~access;
                if (access) begin
                    state_next = cfg_follow;
                end
            end
            IDLE: begin
                init_done_next = 1'b1;
                if (gpio_irq && !evt_valid) begin
                    state_next  = RD_IRQ;
                    access_next = 1'b0;
                end
            end
            RD_IRQ: begin
                psel_next    = 1'b1;
                penable_next = access;
                paddr_next   = GPIO_BASE + OFF_IRQ;
                pwrite_next  = 1'b0;
                access_next  = ~access;
                if (access) begin
                    state_next = CLR_IRQ;
                end
            end
            CLR_IRQ: begin
                if (!access) begin
                    // The bus is still in the read ACCESS cycle here, so PRDATA is valid.
                    evt_data_next = PRDATA;
                    if (PRDATA == 32'h0) begin
                        state_next = IDLE;
                    end else begin
                        psel_next   = 1'b1;
                        paddr_next  = GPIO_BASE + OFF_IRQ;
                        pwrite_next = 1'b1;
                        pwdata_next = 32'h0;
                        access_next = 1'b1;
                    end
                end else begin
                    psel_next    = 1'b1;
                    penable_next = 1'b1;
                    access_next  = 1'b0;
                    state_next   = PUSH;
                end
            end
            PUSH: begin
                evt_valid_next = 1'b1;
                if (evt_count != 16'hFFFF) begin
                    evt_count_next = evt_count + 16'h1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next  = W_CTRL;
                access_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gpio_irq_sequencer.sv
// Directed bench for gpio_irq_sequencer with a minimal GPIO IRQ register model.
module tb_gpio_irq_sequencer;

    logic        PCLK;
    logic        PRESETn;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        gpio_irq;
    logic        init_done;
    logic        evt_valid;
    logic        evt_ready;
    logic [31:0] evt_data;
    logic [15:0] evt_count;

    logic [31:0] pending;
    int          irq_reads;
    int          irq_clears;
    int          errors;
    int          checks;
    int          busy_cycles;
    logic [31:0] exp_addr [8];
    logic [31:0] exp_data [8];

    gpio_irq_sequencer dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .gpio_irq  (gpio_irq),
        .init_done (init_done),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_count (evt_count)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    assign PRDATA = (PSEL && !PWRITE && PADDR == 32'h0000_000C) ? pending : 32'h0;

    // Counts completed IRQ register reads and clear writes seen on the bus.
    always @(posedge PCLK) begin
        if (PSEL && PENABLE && PADDR == 32'h0000_000C) begin
            if (PWRITE) irq_clears <= irq_clears + 1;
            else        irq_reads  <= irq_reads + 1;
        end
    end

    task automatic stepClock();
        @(posedge PCLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] vec);
        pending   = vec;
        gpio_irq  = 1'b1;
        evt_ready = 1'b0;
    endtask

    task automatic checkConfigSequence();
        for (int k = 0; k < 8; k++) begin
            stepClock();
            checkOutput("cfg_psel",    32'(PSEL),    32'h1);
            checkOutput("cfg_penable", 32'(PENABLE), 32'(k % 2));
            checkOutput("cfg_paddr",   PADDR,        exp_addr[k]);
            checkOutput("cfg_pwrite",  32'(PWRITE),  32'h1);
            checkOutput("cfg_pwdata",  PWDATA,       exp_data[k]);
            checkOutput("cfg_init_lo", 32'(init_done), 32'h0);
        end
        stepClock();
        checkOutput("cfg_end_psel", 32'(PSEL),      32'h0);
        checkOutput("cfg_init_hi",  32'(init_done), 32'h1);
    endtask

    // Drives one non-spurious interrupt and follows it to evt_valid without handshaking.
    task automatic serviceEvent(input logic [31:0] vec, input logic [15:0] exp_count);
        applyStimulus(vec);
        stepClock();
        stepClock();
        checkOutput("rd_setup_psel",    32'(PSEL),    32'h1);
        checkOutput("rd_setup_penable", 32'(PENABLE), 32'h0);
        checkOutput("rd_paddr",         PADDR,        32'h0000_000C);
        checkOutput("rd_pwrite",        32'(PWRITE),  32'h0);
        stepClock();
        checkOutput("rd_access_penable", 32'(PENABLE), 32'h1);
        stepClock();
        checkOutput("clr_setup_psel", 32'(PSEL),    32'h1);
        checkOutput("clr_pwrite",     32'(PWRITE),  32'h1);
        checkOutput("clr_pwdata",     PWDATA,       32'h0);
        checkOutput("clr_paddr",      PADDR,        32'h0000_000C);
        checkOutput("evt_data_cap",   evt_data,     vec);
        stepClock();
        checkOutput("clr_access_penable", 32'(PENABLE), 32'h1);
        gpio_irq = 1'b0;
        pending  = 32'h0;
        stepClock();
        checkOutput("evt_valid_set", 32'(evt_valid), 32'h1);
        checkOutput("evt_data",      evt_data,       vec);
        checkOutput("evt_count",     32'(evt_count), 32'(exp_count));
        checkOutput("idle_psel",     32'(PSEL),      32'h0);
    endtask

    task automatic handshake();
        evt_ready = 1'b1;
        stepClock();
        evt_ready = 1'b0;
        checkOutput("evt_valid_clr", 32'(evt_valid), 32'h0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        irq_reads  = 0;
        irq_clears = 0;
        pending    = 32'h0;
        gpio_irq   = 1'b0;
        evt_ready  = 1'b0;
        PRESETn    = 1'b0;
        exp_addr[0] = 32'h00; exp_addr[1] = 32'h00; exp_addr[2] = 32'h10; exp_addr[3] = 32'h10;
        exp_addr[4] = 32'h14; exp_addr[5] = 32'h14; exp_addr[6] = 32'h08; exp_addr[7] = 32'h08;
        exp_data[0] = 32'h0;  exp_data[1] = 32'h0;
        exp_data[2] = 32'hFFFF_FFFF; exp_data[3] = 32'hFFFF_FFFF;
        exp_data[4] = 32'hFFFF_FFFF; exp_data[5] = 32'hFFFF_FFFF;
        exp_data[6] = 32'h0;  exp_data[7] = 32'h0;

        $display("[TB] reset state and configuration sequence");
        stepClock();
        stepClock();
        checkOutput("rst_psel",      32'(PSEL),      32'h0);
        checkOutput("rst_penable",   32'(PENABLE),   32'h0);
        checkOutput("rst_paddr",     PADDR,          32'h0);
        checkOutput("rst_pwdata",    PWDATA,         32'h0);
        checkOutput("rst_init_done", 32'(init_done), 32'h0);
        checkOutput("rst_evt_valid", 32'(evt_valid), 32'h0);
        checkOutput("rst_evt_count", 32'(evt_count), 32'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        checkConfigSequence();

        $display("[TB] first interrupt");
        serviceEvent(32'h1234_5678, 16'd1);
        checkOutput("clear_writes_1", 32'(irq_clears), 32'd1);

        $display("[TB] interrupt held off while evt_valid is high");
        applyStimulus(32'h0000_00A5);
        busy_cycles = 0;
        for (int k = 0; k < 6; k++) begin
            stepClock();
            if (PSEL) busy_cycles++;
        end
        checkOutput("no_bus_while_valid", 32'(busy_cycles), 32'h0);
        checkOutput("evt_data_hold",      evt_data,         32'h1234_5678);
        handshake();
        serviceEvent(32'h0000_00A5, 16'd2);
        handshake();
        checkOutput("reads_2", 32'(irq_reads), 32'd2);

        $display("[TB] spurious interrupt");
        applyStimulus(32'h0);
        stepClock();
        gpio_irq = 1'b0;
        for (int k = 0; k < 6; k++) stepClock();
        checkOutput("spur_reads",     32'(irq_reads),  32'd3);
        checkOutput("spur_clears",    32'(irq_clears), 32'd2);
        checkOutput("spur_evt_valid", 32'(evt_valid),  32'h0);
        checkOutput("spur_evt_count", 32'(evt_count),  32'd2);

        $display("[TB] reset during clear access");
        applyStimulus(32'h0000_0003);
        for (int k = 0; k < 5; k++) stepClock();
        checkOutput("pre_rst_penable", 32'(PENABLE), 32'h1);
        checkOutput("pre_rst_pwrite",  32'(PWRITE),  32'h1);
        PRESETn = 1'b0;
        #1;
        checkOutput("mid_rst_psel",      32'(PSEL),      32'h0);
        checkOutput("mid_rst_penable",   32'(PENABLE),   32'h0);
        checkOutput("mid_rst_evt_count", 32'(evt_count), 32'h0);
        checkOutput("mid_rst_init_done", 32'(init_done), 32'h0);
        gpio_irq = 1'b0;
        pending  = 32'h0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        checkConfigSequence();
        checkOutput("rst_clears_unchanged", 32'(irq_clears), 32'd2);

        $display("[TB] evt_count saturation");
        force dut.evt_count = 16'hFFFE;
        stepClock();
        release dut.evt_count;
        serviceEvent(32'h8000_0000, 16'hFFFF);
        handshake();
        serviceEvent(32'h0000_0001, 16'hFFFF);
        handshake();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
